// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC rotator: Q2.29 format, gain correction, arctangent table,
// controller states and the quadrant sign rule.
package cordic_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_BITS = 29;

  // 1/K for the infinite CORDIC gain, 0.6072529350 in Q2.29.
  localparam logic signed [31:0] K_INV = 32'sd326016437;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    FIXUP,
    DONE
  } state_t;

  // Quadrant code: bit 1 negates the sine, bit 0 negates the cosine.
  localparam int Q_SIN_NEG_BIT = 1;
  localparam int Q_COS_NEG_BIT = 0;

  function automatic logic [1:0] quad_signs(input logic [1:0] q);
    return {q[Q_SIN_NEG_BIT], q[Q_COS_NEG_BIT]};
  endfunction

  // atan(2^-i) in Q2.29.
  function automatic logic signed [31:0] atan_tab(input logic [4:0] i);
    logic signed [31:0] v;
    case (i)
      5'd0:  v = 32'sd421657428;
      5'd1:  v = 32'sd248918915;
      5'd2:  v = 32'sd131521918;
      5'd3:  v = 32'sd66762579;
      5'd4:  v = 32'sd33510843;
      5'd5:  v = 32'sd16771758;
      5'd6:  v = 32'sd8387925;
      5'd7:  v = 32'sd4194219;
      5'd8:  v = 32'sd2097141;
      5'd9:  v = 32'sd1048575;
      5'd10: v = 32'sd524288;
      5'd11: v = 32'sd262144;
      5'd12: v = 32'sd131072;
      5'd13: v = 32'sd65536;
      5'd14: v = 32'sd32768;
      5'd15: v = 32'sd16384;
      5'd16: v = 32'sd8192;
      5'd17: v = 32'sd4096;
      5'd18: v = 32'sd2048;
      5'd19: v = 32'sd1024;
      5'd20: v = 32'sd512;
      5'd21: v = 32'sd256;
      5'd22: v = 32'sd128;
      5'd23: v = 32'sd64;
      5'd24: v = 32'sd32;
      5'd25: v = 32'sd16;
      5'd26: v = 32'sd8;
      5'd27: v = 32'sd4;
      5'd28: v = 32'sd2;
      5'd29: v = 32'sd1;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_rotator_if.sv
// Angle-in / sin-cos-out handshake bundle between the quadrant reducer, the rotator and its consumer.
interface cordic_rotator_if #(
  parameter int WIDTH = 32
);
  logic signed [WIDTH-1:0] angle_in;
  logic                    angle_valid;
  logic [1:0]              quad_data;
  logic                    in_ready;
  logic signed [WIDTH-1:0] sin_out;
  logic signed [WIDTH-1:0] cos_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    drop_err;

  modport master (
    output angle_in, angle_valid, quad_data, out_ready,
    input  in_ready, sin_out, cos_out, out_valid, drop_err
  );

  modport slave (
    input  angle_in, angle_valid, quad_data, out_ready,
    output in_ready, sin_out, cos_out, out_valid, drop_err
  );
endinterface

// File: rtl/cordic_iter.sv
// One combinational CORDIC micro-rotation; direction follows the sign of the residual angle z.
module cordic_iter #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic        [SW-1:0]    shift,
  input  logic signed [WIDTH-1:0] atan_val,
  output logic signed [WIDTH-1:0] x_nxt,
  output logic signed [WIDTH-1:0] y_nxt,
  output logic signed [WIDTH-1:0] z_nxt
);

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;

  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    if (!z[WIDTH-1]) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan_val;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan_val;
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle on a shared datapath, then quadrant
// sign restore; result held under out_valid until out_ready. Supports WIDTH up to 32.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = 24
) (
  input logic             clk,
  input logic             rst,
  cordic_rotator_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic signed [WIDTH-1:0] K_INV_W = WIDTH'(K_INV >>> (32 - WIDTH));

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [WIDTH-1:0] atan_val;
  logic signed [31:0]      atan_full;
  logic [1:0]              q;
  logic [1:0]              sgn;
  logic signed [WIDTH-1:0] sin_r, cos_r;
  logic                    out_valid_r;
  logic                    drop_r;

  // Table is Q2.29 at 32 bits; rescale to the Q2.(WIDTH-3) datapath.
  assign atan_full = atan_tab(5'(cnt));
  assign atan_val  = WIDTH'(atan_full >>> (32 - WIDTH));
  assign sgn       = quad_signs(q);

  cordic_iter #(
    .WIDTH(WIDTH),
    .SW   (CW)
  ) u_iter (
    .x       (x),
    .y       (y),
    .z       (z),
    .shift   (cnt),
    .atan_val(atan_val),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .z_nxt   (z_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      q           <= '0;
      sin_r       <= '0;
      cos_r       <= '0;
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      if (bus.angle_valid && (state != IDLE)) begin
        drop_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.angle_valid) begin
            x     <= K_INV_W;
            y     <= '0;
            z     <= bus.angle_in;
            q     <= bus.quad_data;
            cnt   <= '0;
            state <= ROTATE;
          end
        end
        ROTATE: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          if (cnt == CW'(ITER - 1)) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIXUP: begin
          sin_r       <= sgn[1] ? -y : y;
          cos_r       <= sgn[0] ? -x : x;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.sin_out   = sin_r;
  assign bus.cos_out   = cos_r;
  assign bus.out_valid = out_valid_r;
  assign bus.drop_err  = drop_r;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator against a real-arithmetic sin/cos reference.
module tb_cordic_rotator;

  localparam int  W       = 32;
  localparam real SCALE   = 536870912.0;
  localparam int  HALF_PI = 843314857;
  localparam int  TOL     = 512;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cordic_rotator_if #(.WIDTH(W)) bus ();

  cordic_rotator #(
    .WIDTH(W),
    .ITER (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Quadrant table: 00 (+,+), 01 (+,-), 10 (-,+), 11 (-,-) for (sin, cos).
  function automatic longint ref_val(input int ang, input logic [1:0] qd, input bit want_sin);
    real sin_sign [4];
    real cos_sign [4];
    real th;
    real v;
    sin_sign = '{1.0, 1.0, -1.0, -1.0};
    cos_sign = '{1.0, -1.0, 1.0, -1.0};
    th = real'(ang) / SCALE;
    if (want_sin) v = $sin(th) * sin_sign[qd];
    else          v = $cos(th) * cos_sign[qd];
    return longint'(v * SCALE);
  endfunction

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_before_send", longint'(bus.in_ready), 1, 0);
  endtask

  task automatic run(input int ang, input logic [1:0] qd, input int hold,
                     input bit drop_mid, input bit vld_at_handoff);
    int     cyc;
    int     stray;
    bit     seen;
    longint es;
    longint ec;
    es = ref_val(ang, qd, 1'b1);
    ec = ref_val(ang, qd, 1'b0);
    wait_ready();
    bus.angle_in    = ang;
    bus.quad_data   = qd;
    bus.angle_valid = 1'b1;
    @(posedge clk); #1;
    bus.angle_valid = 1'b0;
    check("in_ready_after_accept", longint'(bus.in_ready), 0, 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      if (drop_mid && cyc == 5) begin
        bus.angle_in    = int'($urandom_range(HALF_PI, 0));
        bus.quad_data   = 2'($urandom_range(3, 0));
        bus.angle_valid = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      bus.angle_valid = 1'b0;
      if (drop_mid && cyc == 6) check("drop_err_set", longint'(bus.drop_err), 1, 0);
      seen = bus.out_valid;
    end
    check("latency", longint'(cyc), 25, 0);
    check("sin", longint'(bus.sin_out), es, TOL);
    check("cos", longint'(bus.cos_out), ec, TOL);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", longint'(bus.out_valid), 1, 0);
      check("hold_in_ready", longint'(bus.in_ready), 0, 0);
      check("hold_sin", longint'(bus.sin_out), es, TOL);
      check("hold_cos", longint'(bus.cos_out), ec, TOL);
    end
    bus.out_ready = 1'b1;
    if (vld_at_handoff) begin
      bus.angle_in    = 32'sd421657428;
      bus.quad_data   = 2'b00;
      bus.angle_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready   = 1'b0;
    bus.angle_valid = 1'b0;
    check("handoff_valid_low", longint'(bus.out_valid), 0, 0);
    check("handoff_in_ready", longint'(bus.in_ready), 1, 0);
    if (vld_at_handoff) begin
      check("handoff_drop_err", longint'(bus.drop_err), 1, 0);
      stray = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (bus.out_valid || !bus.in_ready) stray++;
      end
      check("handoff_not_accepted", longint'(stray), 0, 0);
    end
  endtask

  initial begin
    int stray;
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    bus.angle_in    = '0;
    bus.angle_valid = 1'b0;
    bus.quad_data   = 2'b00;
    bus.out_ready   = 1'b0;

    #3 rst = 1'b0;
    #1;
    check("rst_in_ready", longint'(bus.in_ready), 1, 0);
    check("rst_out_valid", longint'(bus.out_valid), 0, 0);
    check("rst_sin", longint'(bus.sin_out), 0, 0);
    check("rst_cos", longint'(bus.cos_out), 0, 0);
    check("rst_drop_err", longint'(bus.drop_err), 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run(0, 2'b00, 0, 1'b0, 1'b0);
    check("drop_err_idle", longint'(bus.drop_err), 0, 0);
    run(HALF_PI, 2'b00, 10, 1'b1, 1'b0);
    run(281104952, 2'b01, 0, 1'b0, 1'b0);
    run(421657428, 2'b10, 2, 1'b0, 1'b0);
    run(421657428, 2'b11, 0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      run(int'($urandom_range(HALF_PI, 0)), 2'($urandom_range(3, 0)),
          int'($urandom_range(3, 0)), 1'b0, 1'b0);
    end

    // Reset in the middle of a rotation must discard it cleanly.
    run(281104952, 2'b01, 0, 1'b0, 1'b0);
    check("drop_err_sticky", longint'(bus.drop_err), 1, 0);
    wait_ready();
    bus.angle_in    = 32'sd600000000;
    bus.quad_data   = 2'b00;
    bus.angle_valid = 1'b1;
    @(posedge clk); #1;
    bus.angle_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_out_valid", longint'(bus.out_valid), 0, 0);
    check("midrst_sin", longint'(bus.sin_out), 0, 0);
    check("midrst_cos", longint'(bus.cos_out), 0, 0);
    check("midrst_drop_err", longint'(bus.drop_err), 0, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", longint'(bus.in_ready), 1, 0);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray++;
    end
    check("midrst_no_stale_valid", longint'(stray), 0, 0);
    run(HALF_PI / 3, 2'b00, 0, 1'b0, 1'b0);

    run(281104952, 2'b01, 1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
